square_iter: RTL and testbench
==============================

Name: square_iter

Overview:
- Sequential, parametrised successor to the combinational single-square-with-refresh unit in the CLM redundant-representation datapath.
- Computes x^(2^k) on an (8+d)-bit redundant GF(2^8) element by applying k squarings, one per clock.
- Each squaring performs its modular reduction with a fresh d-bit random polynomial drawn over a valid/ready handshake.
- Sits between the masked inversion sequencer and the randomness source. It replaces chains of combinational square instances with one reusable engine.

Parameters:
- d, 2, redundancy bits; state width W = 8+d.
- max_k, 8, maximum number of squarings per operation.
- kw, $clog2(max_k+1), width of k port (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept an operand.
- in_data  in  W  operand x, bit index 0 = constant coefficient, [0:W-1].
- k  in  kw  squaring count, sampled with in_data.
- B_ext  in  (7+2d)x8  reduction matrix, row j / column i, sampled with in_data.
- r_data  in  d  random reduction polynomial.
- r_valid  in  1  r_data valid.
- r_ready  out  1  block consumes r_data this cycle if r_valid.
- out_data  out  W  result x^(2^k).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. acc, cnt and the B_ext register clear to 0. Outputs: in_ready=1, out_valid=0, r_ready=0, busy=0, out_data=0.
- Reset asserted mid-operation aborts the operation. No output is produced and no further r handshakes occur.
- FSM IDLE: in_ready=1.
  - On in_valid: latch acc=in_data and latch B_ext.
  - keff = min(k, max_k); cnt=keff.
  - If keff==0, go to DONE; otherwise go to RUN.
- FSM RUN: r_ready=1. In each cycle with r_valid=1:
  - acc = sq(acc, r_data); cnt--.
  - When cnt reaches 0, go to DONE.
  - If r_valid=0, the block stalls: acc and cnt hold.
- FSM DONE: out_valid=1, out_data=acc.
  - On out_ready, go to IDLE.
  - out_data is stable while out_valid=1 and out_ready=0.
- No new operand is accepted until the handshake completes; in_ready is low in RUN and DONE.
- Latency with r_valid held high: out_valid rises keff+1 cycles after the accept edge (keff=0 gives 1 cycle).
- Exactly keff r handshakes occur per operation.
- Squaring sq(a, r):
  - Form p[0:14+2d] with p[2i]=a[i] for i in 0..7+d; all odd bits are 0.
  - Form v[0:6+2d] = {r, p[8+d:14+2d]}, with r at v[0:d-1].
  - t[i] = XOR over j of (v[j] & B_ext[j][i]) for i in 0..7.
  - t[8:7+d] = r.
  - Result = p[0:7+d] ^ t.
- B_ext changes while busy have no effect; the latched copy is used.
- k values above max_k are clamped; no error is flagged.

Test Plan:
- d=2, B_ext=0, in_data=10'b1000000000, k=1, r=2'b11 -> out_data=10'b1000000011; 1 r handshake; out_valid 2 cycles after accept.
- d=2, B_ext=0, in_data=10'b0100000000, k=2, r=00 twice -> out_data=10'b0000100000 (index 4); out_valid 3 cycles after accept.
- d=2, B_ext row 2 ones at columns 0,1,3,4, other rows 0, in_data index 5 set, k=1, r=00 -> out_data bits 0,1,3,4 set, others 0.
- k=0 with any in_data -> out_data=in_data one cycle after accept, r_ready never asserted. k=15 (kw=4, max_k=8) -> exactly 8 r handshakes.
- Stall r_valid low 3 cycles mid-run, then hold out_ready low 5 cycles -> result identical to the unstalled run, out_valid delayed by 3 cycles, out_data stable and in_ready=0 throughout.
- rst_n pulsed low during RUN -> in_ready=1, out_valid=0, r_ready=0, out_data=0 immediately; the next operand completes correctly.

Source files
------------

// File: rtl/square_iter_if.sv
// Handshake and operand bus for the square_iter engine.
//   master side: offers operands (in_*, k, B_ext), supplies randomness
//                (r_data/r_valid) and accepts results (out_ready).
//   slave side : the engine; returns in_ready, r_ready, out_data,
//                out_valid and busy.
// Bit 0 of every GF(2^8) vector is the constant coefficient (ascending ranges).
interface square_iter_if #(
    parameter int d     = 2,
    parameter int max_k = 8
);
    localparam int W  = 8 + d;
    localparam int kw = $clog2(max_k + 1);

    logic                      in_valid;
    logic                      in_ready;
    logic [0:W-1]              in_data;
    logic [kw-1:0]             k;
    logic [0:6+2*d][0:7]       B_ext;
    logic [0:d-1]              r_data;
    logic                      r_valid;
    logic                      r_ready;
    logic [0:W-1]              out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      busy;

    modport master (
        output in_valid, in_data, k, B_ext, r_data, r_valid, out_ready,
        input  in_ready, r_ready, out_data, out_valid, busy
    );

    modport slave (
        input  in_valid, in_data, k, B_ext, r_data, r_valid, out_ready,
        output in_ready, r_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/square_iter.sv
// Iterative squarer for (8+d)-bit redundant GF(2^8) elements: computes
// x^(2^k) by applying one randomised squaring per clock.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - square_iter_if.slave: operand handshake (in_valid/in_ready,
//            in_data, k, B_ext), randomness handshake (r_data, r_valid,
//            r_ready), result handshake (out_data, out_valid, out_ready),
//            busy status.
module square_iter #(
    parameter int d     = 2,
    parameter int max_k = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    square_iter_if.slave  bus
);
    localparam int W  = 8 + d;
    localparam int VW = 7 + 2 * d;
    localparam int PW = 15 + 2 * d;
    localparam int kw = $clog2(max_k + 1);

    typedef logic [0:VW-1][0:7] bmat_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [0:W-1]  acc;
    logic [kw-1:0] cnt;
    logic [kw-1:0] keff;
    bmat_t         b_reg;

    // One redundant squaring: spread coefficients to even positions, then
    // fold the fresh random polynomial plus the overflow part back through
    // the reduction matrix into the low byte.
    function automatic logic [0:W-1] sq(input logic [0:W-1] a,
                                         input logic [0:d-1] r,
                                         input bmat_t        b);
        logic [0:PW-1] p;
        logic [0:VW-1] v;
        logic [0:W-1]  t;
        p = '0;
        for (int i = 0; i < W; i++) p[2*i] = a[i];
        for (int j = 0; j < d; j++) v[j] = r[j];
        for (int j = 0; j < 7 + d; j++) v[d+j] = p[8+d+j];
        t = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < VW; j++)
                t[i] = t[i] ^ (v[j] & b[j][i]);
        for (int j = 0; j < d; j++) t[8+j] = r[j];
        return p[0:W-1] ^ t;
    endfunction

    // Oversized squaring counts are silently clamped.
    assign keff = (bus.k > kw'(max_k)) ? kw'(max_k) : bus.k;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = (keff == '0) ? DONE : RUN;
            RUN:  if (bus.r_valid && cnt == kw'(1)) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.r_ready   = (state == RUN);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.out_data  = (state == DONE) ? acc : '0;
    end

    // Datapath: operand/matrix capture on accept, one squaring per r beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            b_reg <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    acc   <= bus.in_data;
                    b_reg <= bus.B_ext;
                    cnt   <= keff;
                end
                RUN: if (bus.r_valid) begin
                    acc <= sq(acc, bus.r_data, b_reg);
                    cnt <= cnt - kw'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_square_iter.sv
// Randomised self-checking bench for square_iter (d=2, max_k=8).
// A reference model treats the operand as a polynomial, doubles each
// coefficient degree and folds overflow degrees and the random polynomial
// back through the matrix rows; the r values the engine actually consumed
// are recorded and replayed through the model.
module tb_square_iter;
    localparam int D    = 2;
    localparam int MAXK = 8;
    localparam int W    = 8 + D;

    typedef logic [0:6+2*D][0:7] bmat_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [0:D-1] r_q[$];
    int           stall_left = 0;
    bit           r_fixed_en = 0;
    logic [0:D-1] r_fixed    = '0;

    square_iter_if #(.d(D), .max_k(MAXK)) bus ();

    square_iter #(.d(D), .max_k(MAXK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Squaring as polynomial arithmetic: degree i -> 2i; degrees >= 8
    // (other than the redundant positions 8..W-1) are replaced by matrix row
    // (degree-8); the random polynomial adds r*x^8 and its matrix rows.
    function automatic logic [0:W-1] m_sq(input logic [0:W-1] a, input logic [0:D-1] r, input bmat_t b);
        logic [0:W-1] res;
        logic [0:7]   t;
        res = '0;
        t   = '0;
        for (int i = 0; i < W; i++) begin
            if (2 * i < W) res[2*i] = a[i];
            else if (a[i]) t = t ^ b[2*i-8];
        end
        for (int j = 0; j < D; j++)
            if (r[j]) begin
                t = t ^ b[j];
                res[8+j] = ~res[8+j];
            end
        res[0:7] = res[0:7] ^ t;
        return res;
    endfunction

    function automatic bmat_t rand_b();
        bmat_t b;
        for (int j = 0; j <= 6 + 2 * D; j++) b[j] = 8'($urandom);
        return b;
    endfunction

    // Randomness source: r_valid high except during requested stalls.
    initial begin
        bus.r_valid = 0;
        bus.r_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.r_valid = 0;
                stall_left--;
            end else begin
                bus.r_valid = 1;
            end
            bus.r_data = r_fixed_en ? r_fixed : D'($urandom);
        end
    end

    // Record every r beat the engine consumes.
    initial forever begin
        @(negedge clk);
        if (bus.r_valid && bus.r_ready) r_q.push_back(bus.r_data);
    end

    task automatic run_op(input logic [0:W-1] x, input logic [3:0] kk, input bmat_t b,
                          input bit stall, input int hold, output logic [0:W-1] res);
        int keff, lat, guard, exp_lat;
        logic [0:W-1] a;
        keff  = (kk > MAXK) ? MAXK : int'(kk);
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        r_q.delete();
        bus.in_valid = 1;
        bus.in_data  = x;
        bus.k        = kk;
        bus.B_ext    = b;
        @(posedge clk); #1;
        bus.in_valid = 0;
        bus.in_data  = W'($urandom);
        bus.B_ext    = rand_b();
        lat = 1;
        if (stall) begin
            @(negedge clk);
            stall_left = 3;
        end
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        exp_lat = keff + 1 + (stall ? 3 : 0);
        check("latency", lat, exp_lat);
        res = bus.out_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, res);
            check("hold_in_ready", bus.in_ready, 0);
        end
        check("busy_done", bus.busy, 1);
        bus.out_ready = 1;
        @(posedge clk); #1;
        bus.out_ready = 0;
        check("valid_cleared", bus.out_valid, 0);
        check("in_ready_back", bus.in_ready, 1);
        check("r_beats", r_q.size(), keff);
        a = x;
        foreach (r_q[i]) a = m_sq(a, r_q[i], b);
        check("model_data", res, a);
    endtask

    initial begin
        logic [0:W-1] res, res_a, x;
        bmat_t b;
        logic [3:0] kk;
        bit st;
        int ke;

        rst_n         = 0;
        bus.in_valid  = 0;
        bus.in_data   = '0;
        bus.k         = '0;
        bus.B_ext     = '0;
        bus.out_ready = 0;
        #23;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_r_ready", bus.r_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Constant coefficient, B_ext=0, r=11
        r_fixed_en = 1;
        r_fixed    = 2'b11;
        x = 10'b1000000000;
        run_op(x, 4'd1, '0, 0, 0, res);
        check("t1_data", res, 10'b1000000011);

        // x squared twice -> x^4
        r_fixed = 2'b00;
        x = 10'b0100000000;
        run_op(x, 4'd2, '0, 0, 0, res);
        check("t2_data", res, 10'b0000100000);

        // Overflow degree 10 reduced through matrix row 2
        b = '0;
        b[2] = 8'b11011000;
        x = 10'b0000010000;
        run_op(x, 4'd1, b, 0, 0, res);
        check("t3_data", res, 10'b1101100000);

        // k=0 passes operand through, no r beats
        r_fixed_en = 0;
        x = W'($urandom);
        run_op(x, 4'd0, rand_b(), 0, 0, res);
        check("k0_data", res, x);

        // k=15 clamps to 8 beats
        run_op(W'($urandom), 4'd15, rand_b(), 0, 0, res);

        // Stalled run matches unstalled run with the same r stream
        r_fixed_en = 1;
        r_fixed    = 2'b10;
        x = W'($urandom);
        b = rand_b();
        run_op(x, 4'd5, b, 0, 0, res_a);
        run_op(x, 4'd5, b, 1, 5, res);
        check("stall_same", res, res_a);
        r_fixed_en = 0;

        // Reset mid-run aborts cleanly
        bus.in_valid = 1;
        bus.in_data  = W'($urandom);
        bus.k        = 4'd8;
        bus.B_ext    = rand_b();
        @(posedge clk); #1;
        bus.in_valid = 0;
        @(posedge clk); #1;
        check("pre_rst_busy", bus.busy, 1);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_r_ready", bus.r_ready, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        check("post_rst_valid", bus.out_valid, 0);
        run_op(W'($urandom), 4'd3, rand_b(), 0, 0, res);

        // Random operations
        for (int n = 0; n < 20; n++) begin
            kk = 4'($urandom_range(0, 15));
            ke = (kk > MAXK) ? MAXK : int'(kk);
            st = (ke >= 2) && ($urandom_range(0, 1) == 1);
            run_op(W'($urandom), kk, rand_b(), st, $urandom_range(0, 3), res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
